uart_mem_bridge: RTL and testbench

Sits between the UART word assembler and the instruction/data memories. It buffers received words (`on_received`, `addr`, `recv_data`) in a small FIFO and commits them to IM or DM through a granted write port, keeping a running checksum. In dump mode it serves the assembler's `data_to_send` by reading DM at the requested word address. It owns the memory port only while it has work, so the CPU keeps access otherwise.

---
 rtl/uart_mem_bridge_pkg.sv | 14 +
 rtl/uart_mem_bridge_fifo.sv | 60 ++++++
 rtl/uart_mem_bridge.sv | 156 +++++++++++++++
 tb/tb_uart_mem_bridge.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mem_bridge_pkg.sv
// rtl/uart_mem_bridge_pkg.sv - shared FSM encoding and memory target ids for the UART memory bridge
package uart_mem_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_RDW  = 2'd3
  } state_e;

  localparam logic RAM_IM = 1'b0;
  localparam logic RAM_DM = 1'b1;

endpackage

// File: rtl/uart_mem_bridge_fifo.sv
// rtl/uart_mem_bridge_fifo.sv - small synchronous FIFO holding received words until committed
module bridge_fifo #(
  parameter int WIDTH     = 41,
  parameter int DEPTH_BIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int DEPTH = 1 << DEPTH_BIT;

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [DEPTH_BIT-1:0] wr_ptr_q;
  logic [DEPTH_BIT-1:0] rd_ptr_q;
  logic [DEPTH_BIT:0]   count_q;
  logic                 do_push;
  logic                 do_pop;

  // The count never exceeds DEPTH, so its top bit alone means full.
  assign full_o  = count_q[DEPTH_BIT];
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Storage array; contents are don't-care until the pointers say otherwise.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop leave the count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_mem_bridge.sv
// rtl/uart_mem_bridge.sv - buffers UART words into IM/DM and serves DM reads for UART dump
module uart_mem_bridge
  import uart_mem_bridge_pkg::*;
#(
  parameter int MAX_SIZE_BIT   = 8,
  parameter int FIFO_DEPTH_BIT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic                  ram_id,
  input  logic                  on_received,
  input  logic [MAX_SIZE_BIT-1:0] addr_in,
  input  logic [31:0]           recv_data,
  input  logic                  mem_grant,
  output logic                  mem_req,
  output logic                  im_we,
  output logic                  dm_we,
  output logic                  dm_re,
  output logic [MAX_SIZE_BIT-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           dm_rdata,
  output logic [31:0]           data_to_send,
  output logic                  send_valid,
  output logic [31:0]           checksum,
  output logic [MAX_SIZE_BIT:0] word_count,
  output logic                  overflow
);

  localparam int ENTRY_W = MAX_SIZE_BIT + 33;
  localparam logic [MAX_SIZE_BIT:0] WC_MAX = {1'b1, {MAX_SIZE_BIT{1'b0}}};

  state_e                  state_q;
  logic [MAX_SIZE_BIT-1:0] mem_addr_q;
  logic [31:0]             mem_wdata_q;
  logic                    tgt_q;
  logic [MAX_SIZE_BIT-1:0] served_q;
  logic [31:0]             data_to_send_q;
  logic                    send_valid_q;
  logic [31:0]             checksum_q;
  logic [MAX_SIZE_BIT:0]   word_count_q;
  logic [MAX_SIZE_BIT:0]   word_count_d;
  logic                    overflow_q;

  logic [ENTRY_W-1:0]      fifo_head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    addr_moved;

  assign fifo_push  = on_received && !fifo_full;
  assign fifo_pop   = (state_q == ST_WR) && mem_grant;
  assign addr_moved = (addr_in != served_q);

  bridge_fifo #(
    .WIDTH     (ENTRY_W),
    .DEPTH_BIT (FIFO_DEPTH_BIT)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({ram_id, addr_in, recv_data}),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Port strobes follow the grant directly so no cycle is lost waiting for a registered enable.
  always_comb begin
    mem_req = (state_q == ST_WR) || (state_q == ST_RD);
    im_we   = (state_q == ST_WR) && mem_grant && (tgt_q == RAM_IM);
    dm_we   = (state_q == ST_WR) && mem_grant && (tgt_q == RAM_DM);
    dm_re   = (state_q == ST_RD) && mem_grant;
  end

  // The count stops at 2^MAX_SIZE_BIT instead of wrapping back to zero.
  always_comb begin
    word_count_d = (word_count_q == WC_MAX) ? WC_MAX : word_count_q + 1'b1;
  end

  // Main sequencer: queued writes always win over dump reads, so a mode flip drains first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      tgt_q          <= RAM_IM;
      served_q       <= '0;
      data_to_send_q <= '0;
      send_valid_q   <= 1'b0;
      checksum_q     <= '0;
      word_count_q   <= '0;
    end else begin
      if (send_valid_q && addr_moved) begin
        send_valid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            tgt_q       <= fifo_head[ENTRY_W-1];
            mem_addr_q  <= fifo_head[ENTRY_W-2:32];
            mem_wdata_q <= fifo_head[31:0];
            state_q     <= ST_WR;
          end else if (mode && (!send_valid_q || addr_moved)) begin
            mem_addr_q <= addr_in;
            state_q    <= ST_RD;
          end
        end
        ST_WR: begin
          if (mem_grant) begin
            checksum_q   <= checksum_q + mem_wdata_q;
            word_count_q <= word_count_d;
            state_q      <= ST_IDLE;
          end
        end
        ST_RD: begin
          // Keep following the requested address while waiting for the port.
          if (mem_grant) begin
            served_q     <= mem_addr_q;
            send_valid_q <= 1'b0;
            state_q      <= ST_RDW;
          end else begin
            mem_addr_q <= addr_in;
          end
        end
        ST_RDW: begin
          // If the address moved during the read, leave valid low so IDLE re-reads.
          data_to_send_q <= dm_rdata;
          send_valid_q   <= !addr_moved;
          state_q        <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // A strobe arriving while the FIFO is full loses its word; remember that until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (on_received && fifo_full) begin
      overflow_q <= 1'b1;
    end
  end

  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign data_to_send = data_to_send_q;
  assign send_valid   = send_valid_q;
  assign checksum     = checksum_q;
  assign word_count   = word_count_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// tb/tb_uart_mem_bridge.sv - self-checking bench for uart_mem_bridge
module tb_uart_mem_bridge;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic        ram_id;
  logic        on_received;
  logic [7:0]  addr_in;
  logic [31:0] recv_data;
  logic        mem_grant;
  logic        mem_req;
  logic        im_we;
  logic        dm_we;
  logic        dm_re;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] dm_rdata;
  logic [31:0] data_to_send;
  logic        send_valid;
  logic [31:0] checksum;
  logic [8:0]  word_count;
  logic        overflow;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;

  logic [40:0] exp_q [$];
  logic [31:0] m_sum;
  int          m_cnt;
  logic        m_ovf;
  logic [31:0] ref_dm [int];
  int          dm_written [$];
  logic [31:0] dm_mem [256];

  logic        mon_full;
  logic [40:0] mon_e;
  logic [41:0] mon_got;
  logic [41:0] mon_want;

  uart_mem_bridge #(.MAX_SIZE_BIT(8), .FIFO_DEPTH_BIT(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode         (mode),
    .ram_id       (ram_id),
    .on_received  (on_received),
    .addr_in      (addr_in),
    .recv_data    (recv_data),
    .mem_grant    (mem_grant),
    .mem_req      (mem_req),
    .im_we        (im_we),
    .dm_we        (dm_we),
    .dm_re        (dm_re),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .dm_rdata     (dm_rdata),
    .data_to_send (data_to_send),
    .send_valid   (send_valid),
    .checksum     (checksum),
    .word_count   (word_count),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // Data memory device: one-cycle read latency.
  always @(posedge clk) begin
    if (dm_we) dm_mem[mem_addr] <= mem_wdata;
    if (dm_re) dm_rdata <= dm_mem[mem_addr];
  end

  // Reference model: FIFO of accepted words, each must appear as the next committed write.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_sum = 32'h0;
      m_cnt = 0;
      m_ovf = 1'b0;
    end else begin
      mon_full = (exp_q.size() == 4);
      if (im_we || dm_we) begin
        mon_got = {im_we, dm_we, mem_addr, mem_wdata};
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          mon_want = {~mon_e[40], mon_e[40], mon_e[39:0]};
        end else begin
          mon_e = '0;
          mon_want = '1;
        end
        tests++;
        assert (mon_got === mon_want) else begin
          fails++;
          $error("FAIL write_content: observed %h expected %h", mon_got, mon_want);
        end
        wr_cnt++;
        m_sum = m_sum + mon_e[31:0];
        if (m_cnt < 256) m_cnt++;
        if (mon_e[40]) begin
          ref_dm[int'(mon_e[39:32])] = mon_e[31:0];
          dm_written.push_back(int'(mon_e[39:32]));
        end
      end
      if (on_received) begin
        if (mon_full) m_ovf = 1'b1;
        else exp_q.push_back({ram_id, addr_in, recv_data});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic rid, input logic [7:0] a, input logic [31:0] d);
    on_received = 1'b1;
    ram_id = rid;
    addr_in = a;
    recv_data = d;
    tick();
    on_received = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check({tag, "_timeout"}, 64'd0, 64'd1);
    tick();
    tick();
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!send_valid && n < 30) begin
      tick();
      n++;
    end
    if (n >= 30) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  int base;
  int first_rd_writes;
  bit seen_rd;
  int pick;

  initial begin
    rst_n = 1'b0;
    mode = 1'b0;
    ram_id = 1'b0;
    on_received = 1'b0;
    addr_in = 8'h0;
    recv_data = 32'h0;
    mem_grant = 1'b1;
    repeat (3) tick();
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_im_we", 64'(im_we), 64'd0);
    rst_n = 1'b1;
    tick();
    check("rst_checksum", 64'(checksum), 64'd0);
    check("rst_word_count", 64'(word_count), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_send_valid", 64'(send_valid), 64'd0);
    check("rst_data_to_send", 64'(data_to_send), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);

    // Back-to-back load to IM
    base = wr_cnt;
    for (int i = 0; i < 4; i++) strobe(1'b0, 8'(i), 32'h11111111 * (i + 1));
    drain("t1");
    check("t1_writes", 64'(wr_cnt - base), 64'd4);
    check("t1_checksum", 64'(checksum), 64'hAAAAAAAA);
    check("t1_word_count", 64'(word_count), 64'd4);

    // Overflow with grant held low
    mem_grant = 1'b0;
    base = wr_cnt;
    for (int i = 0; i < 6; i++) strobe(1'b1, 8'(10 + i), $urandom);
    tick();
    check("t2_overflow", 64'(overflow), 64'd1);
    check("t2_no_write", 64'(wr_cnt - base), 64'd0);
    mem_grant = 1'b1;
    drain("t2");
    check("t2_writes", 64'(wr_cnt - base), 64'd4);
    check("t2_checksum", 64'(checksum), 64'(m_sum));

    // Grant stall in WR
    mem_grant = 1'b0;
    base = wr_cnt;
    strobe(1'b0, 8'h33, 32'hCAFEF00D);
    tick();
    for (int i = 0; i < 10; i++) begin
      check("t4_req", 64'(mem_req), 64'd1);
      check("t4_hold", {im_we, dm_we, 22'd0, mem_addr, mem_wdata}, {2'b00, 22'd0, 8'h33, 32'hCAFEF00D});
      tick();
    end
    mem_grant = 1'b1;
    #1;
    check("t4_we_on_grant", 64'(im_we), 64'd1);
    tick();
    tick();
    check("t4_writes", 64'(wr_cnt - base), 64'd1);
    check("t4_word_count", 64'(word_count), 64'(m_cnt));

    // Reset in the middle of a write
    mem_grant = 1'b0;
    base = wr_cnt;
    strobe(1'b0, 8'h40, 32'h5A5A5A5A);
    tick();
    check("t5_in_wr", 64'(mem_req), 64'd1);
    rst_n = 1'b0;
    mem_grant = 1'b1;
    #1;
    check("t5_rst_req", {im_we, dm_we, mem_req}, 64'd0);
    check("t5_rst_checksum", 64'(checksum), 64'd0);
    check("t5_rst_word_count", 64'(word_count), 64'd0);
    check("t5_rst_overflow", 64'(overflow), 64'd0);
    check("t5_rst_mem_addr", 64'(mem_addr), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("t5_no_write", 64'(wr_cnt - base), 64'd0);
    check("t5_idle_req", 64'(mem_req), 64'd0);

    // Dump from DM
    strobe(1'b1, 8'd5, 32'hDEADBEEF);
    strobe(1'b1, 8'd6, 32'h12345678);
    drain("t3_load");
    mode = 1'b1;
    addr_in = 8'd5;
    tick();
    check("t3_dm_re", {dm_re, mem_req, mem_addr}, {1'b1, 1'b1, 8'd5});
    tick();
    check("t3_valid_early", 64'(send_valid), 64'd0);
    tick();
    check("t3_valid", 64'(send_valid), 64'd1);
    check("t3_data", 64'(data_to_send), 64'hDEADBEEF);
    tick();
    tick();
    check("t3_no_reread", 64'(dm_re), 64'd0);
    addr_in = 8'd6;
    tick();
    check("t3_valid_drop", 64'(send_valid), 64'd0);
    wait_valid("t3_addr6");
    check("t3_data6", 64'(data_to_send), 64'h12345678);

    // Mode switch with queued words
    mode = 1'b0;
    mem_grant = 1'b0;
    base = wr_cnt;
    strobe(1'b1, 8'd20, 32'hA0A0A0A0);
    strobe(1'b1, 8'd21, 32'hB1B1B1B1);
    mode = 1'b1;
    mem_grant = 1'b1;
    addr_in = 8'd5;
    seen_rd = 1'b0;
    first_rd_writes = -1;
    for (int i = 0; i < 20; i++) begin
      if (dm_re && !seen_rd) begin
        seen_rd = 1'b1;
        first_rd_writes = wr_cnt - base;
      end
      tick();
    end
    check("t6_drain_before_read", 64'(first_rd_writes), 64'd2);
    check("t6_data", 64'(data_to_send), 64'hDEADBEEF);

    // Randomized load traffic
    mode = 1'b0;
    for (int i = 0; i < 80; i++) begin
      mem_grant = ($urandom_range(0, 3) != 0);
      on_received = $urandom_range(0, 1);
      ram_id = $urandom_range(0, 1);
      addr_in = 8'($urandom_range(0, 255));
      recv_data = $urandom;
      tick();
    end
    on_received = 1'b0;
    mem_grant = 1'b1;
    drain("rnd_load");
    check("rnd_checksum", 64'(checksum), 64'(m_sum));
    check("rnd_word_count", 64'(word_count), 64'(m_cnt));
    check("rnd_overflow", 64'(overflow), 64'(m_ovf));

    // Randomized dump reads of words known to be in DM
    mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pick = dm_written[$urandom_range(0, dm_written.size() - 1)];
      addr_in = 8'(pick);
      tick();
      wait_valid("rnd_dump");
      check("rnd_dump_data", 64'(data_to_send), 64'(ref_dm[pick]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
